// File: rtl/seq_det.sv
// Moore detector for serial pattern 1-0-0-1, first bit earliest.
// Define SEQ_DET_OVERLAP_EN to let a match's trailing 1 start the next.
module seq_det (
  input  logic Seq_in,
  input  logic clk,
  input  logic reset,
  output logic Seq_out
);

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S100  = 3'd3,
    S1001 = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S0;
    case (r_state)
      S0:    w_next = Seq_in ? S1 : S0;
      S1:    w_next = Seq_in ? S1 : S10;
      S10:   w_next = Seq_in ? S1 : S100;
      S100:  w_next = Seq_in ? S1001 : S0;
`ifdef SEQ_DET_OVERLAP_EN
      S1001: w_next = Seq_in ? S1 : S10;
`else
      S1001: w_next = Seq_in ? S1 : S0;
`endif
      // encodings 5..7 recover to idle
      default: w_next = S0;
    endcase
  end

  assign Seq_out = (r_state == S1001);

endmodule

// File: tb/tb_seq_det.sv
// Scoreboard bench for seq_det: stimulus queues the expected
// flag per cycle, a monitor compares after every rising edge.
module tb_seq_det;

  logic clk;
  logic reset;
  logic Seq_in;
  logic Seq_out;

  int n_checks;
  int n_fail;
  logic exp_q[$];

  seq_det dut (
    .Seq_in (Seq_in),
    .clk    (clk),
    .reset  (reset),
    .Seq_out(Seq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic act,
                       input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b",
               name, act, req);
    end
  endtask

  // one bit per cycle; exp is Seq_out after the edge
  task automatic step(input logic b,
                      input logic rst_v,
                      input logic e);
    @(negedge clk);
    Seq_in = b;
    reset  = rst_v;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [63:0] bits,
                      input logic [63:0] exps,
                      input int n);
    for (int i = 0; i < n; i++)
      step(bits[i], 1'b1, exps[i]);
  endtask

  task automatic rst_cycle();
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    logic e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stream", Seq_out, e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    n_checks = 0;
    n_fail   = 0;
    Seq_in   = 1'b0;
    reset    = 1'b0;
    #2;
    check("reset_state", Seq_out, 1'b0);

    rst_cycle();
    send(64'h6664, 64'h2220, 16);

    rst_cycle();
`ifdef SEQ_DET_OVERLAP_EN
    send(64'h49, 64'h48, 7);
`else
    send(64'h49, 64'h08, 7);
`endif

    rst_cycle();
    send(64'h27, 64'h20, 6);

    // reset mid-pattern discards progress
    rst_cycle();
    send(64'h1, 64'h0, 3);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    send(64'h4, 64'h4, 3);

    // async reset while matched
    rst_cycle();
    send(64'h9, 64'h8, 4);
    @(posedge clk);
    #3;
    check("match_before_rst", Seq_out, 1'b1);
    reset = 1'b0;
    #1;
    check("async_drop", Seq_out, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending, required 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det.md
SEQ_DET -- requirements
Module: Seq_det

Interface
REQ-001 Parameters: none; pattern, width and encoding are fixed.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately, reset=1 is normal operation.
REQ-004 Seq_in  input  1  serial data bit, one bit per clk cycle, sampled on rising edge of clk.
REQ-005 Seq_out  output  1  detection flag; high for exactly one cycle per detected pattern.
REQ-006 Port order SHALL be Seq_in, clk, reset, Seq_out to support positional instantiation.

Function
REQ-007 Block SHALL detect the serial bit pattern 1-0-0-1, in arrival order, first bit earliest.
REQ-008 Block SHALL be a Moore FSM; Seq_out depends only on the registered state, never combinationally on Seq_in.
REQ-009 States: S0 (idle/no match), S1 ("1"), S10 ("10"), S100 ("100"), S1001 (match); 3-bit binary encoding 0..4.
REQ-010 Transitions, input 0/1: S0->S0/S1; S1->S10/S1; S10->S100/S1; S100->S0/S1001.
REQ-011 S1001 transitions are defined by REQ-019/REQ-020.
REQ-012 Seq_out SHALL be 1 only in S1001, 0 in all other states.
REQ-013 Latency: Seq_out rises after the rising edge that samples the final '1' of the pattern and stays high for one clk period.
REQ-014 Unused encodings 5..7 SHALL transition to S0 on the next edge with Seq_out=0.
REQ-015 Consecutive '1' inputs SHALL keep the FSM in S1; no detection without a following "001".

Reset
REQ-016 reset=0 SHALL force state to S0 and Seq_out to 0 asynchronously, without waiting for clk.
REQ-017 Reset asserted mid-pattern SHALL discard partial progress; after release, detection restarts from S0.
REQ-018 After reset release, the first rising edge SHALL evaluate Seq_in from S0.

Configuration
REQ-019 Macro SEQ_DET_OVERLAP_EN defined: overlapping detection; S1001 -> S10 on 0, S1 on 1. The trailing '1' of a match starts the next pattern.
REQ-020 Macro SEQ_DET_OVERLAP_EN undefined: non-overlapping detection; S1001 -> S0 on 0, S1 on 1. No bit of a match is reused.

Verification
REQ-021 Hold reset=1, clk period 10 units, drive Seq_in with 16'h6664 LSB first, one bit per cycle. Seq_out SHALL pulse after samples 5, 9 and 13 (0-based), both configurations, 3 pulses total.
REQ-022 Stream 1,0,0,1,0,0,1. With SEQ_DET_OVERLAP_EN: 2 pulses, after bits 3 and 6. Without: 1 pulse, after bit 3.
REQ-023 Stream 1,1,1,0,0,1. Exactly 1 pulse, after the last bit.
REQ-024 Stream 1,0,0, then reset=0 for one cycle, then 1. No pulse; Seq_out=0 throughout.
REQ-025 Drive reset=0 between clock edges while in S1001. Seq_out SHALL drop to 0 before the next rising edge.
REQ-026 Stream all zeros for 20 cycles, then all ones for 20 cycles. Seq_out stays 0.
